// File: rtl/button_pkg.sv
// Shared types and default timing for the button event generators.
// Defaults assume a 25 MHz clock: 10 ms debounce, 160 ms repeat delay, 50 ms repeat period.
package button_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DB_PRESS,
    ST_HOLD_DELAY,
    ST_HOLD_REPEAT,
    ST_DB_RELEASE
  } btn_state_t;

  localparam int CLK_HZ              = 25_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;      // 10 ms
  localparam int DEF_REPEAT_DELAY    = CLK_HZ / 100 * 16; // 160 ms
  localparam int DEF_REPEAT_PERIOD   = CLK_HZ / 20;       // 50 ms

  // Width able to hold the largest of the three timing values.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_event_gen.sv
// Turns a synchronised button level into debounced press/release pulses and
// DAS-style auto-repeat pulses while the button is held.
module button_event_gen
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_sync,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = (REPEAT_DELAY > 0) ? CW'(REPEAT_DELAY - 1) : '0;
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic          rel_start;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    rel_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pressed_d = 1'b0;
        cnt_d     = '0;
        if (btn_sync) begin
          if (DB_LAST == '0) begin
            state_d   = ST_HOLD_DELAY;
            press_d   = 1'b1;
            pressed_d = 1'b1;
          end else begin
            state_d = ST_DB_PRESS;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_DB_PRESS: begin
        if (!btn_sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_HOLD_DELAY;
          cnt_d     = '0;
          press_d   = 1'b1;
          pressed_d = 1'b1;
        end
      end
      ST_HOLD_DELAY: begin
        if (!btn_sync) begin
          rel_start = 1'b1;
        end else if (REPEAT_DELAY > 0 && cnt_q == RD_LAST) begin
          state_d  = ST_HOLD_REPEAT;
          cnt_d    = '0;
          repeat_d = 1'b1;
        end
      end
      ST_HOLD_REPEAT: begin
        if (!btn_sync) begin
          rel_start = 1'b1;
        end else if (cnt_q == RP_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        // A high sample here is bounce: go back to holding and restart the repeat delay.
        if (btn_sync) begin
          state_d = ST_HOLD_DELAY;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        pressed_d = 1'b0;
      end
    endcase

    // First low sample while held counts as release sample 1.
    if (rel_start) begin
      if (DB_LAST == '0) begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        release_d = 1'b1;
        pressed_d = 1'b0;
      end else begin
        state_d = ST_DB_RELEASE;
        cnt_d   = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: a main instance (debounce 4, delay 10, period 3) and a
// repeat-disabled instance share stimulus and are compared against a run-length model.
module tb_button_event_gen;

  localparam int D  = 4;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_sync;
  logic [1:0] pressed, press_p, rel_p, rep_p;

  int checks, passed;

  always #5 clk = ~clk;

  button_event_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(10), .REPEAT_PERIOD(RP)) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_sync(btn_sync),
    .pressed(pressed[0]), .press_pulse(press_p[0]),
    .release_pulse(rel_p[0]), .repeat_pulse(rep_p[0])
  );

  button_event_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) u_dut_norep (
    .clk(clk), .rst_n(rst_n), .btn_sync(btn_sync),
    .pressed(pressed[1]), .press_pulse(press_p[1]),
    .release_pulse(rel_p[1]), .repeat_pulse(rep_p[1])
  );

  // Reference: debounced level flips after D consecutive opposite samples; repeats fall
  // at anchor + RD + k*RP where anchor is the press edge or the latest bounce-back edge.
  int         m_rd[2] = '{10, 0};
  bit         m_level[2];
  int         m_opp[2];
  int         m_anchor[2];
  int         m_edge;
  logic [3:0] m_out[2];

  typedef struct {
    bit         b;
    logic [3:0] exp; // {press, release, repeat, pressed}
  } vec_t;
  vec_t tbl[11];

  function automatic logic [3:0] dut_out(input int i);
    return {press_p[i], rel_p[i], rep_p[i], pressed[i]};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_edge = 0;
    for (int i = 0; i < 2; i++) begin
      m_level[i] = 1'b0; m_opp[i] = 0; m_anchor[i] = 0; m_out[i] = 4'b0000;
    end
  endtask

  task automatic model_step(input bit s);
    m_edge++;
    for (int i = 0; i < 2; i++) begin
      bit pr, rl, rp;
      pr = 0; rl = 0; rp = 0;
      if (s != m_level[i]) begin
        m_opp[i]++;
        if (m_opp[i] == D) begin
          m_level[i] = s;
          m_opp[i]   = 0;
          if (s) begin pr = 1; m_anchor[i] = m_edge; end
          else rl = 1;
        end
      end else if (m_level[i] && m_opp[i] > 0) begin
        m_opp[i]    = 0;
        m_anchor[i] = m_edge;
      end else begin
        m_opp[i] = 0;
        if (m_level[i] && m_rd[i] > 0) begin
          int d;
          d = m_edge - m_anchor[i];
          if (d >= m_rd[i] && (d - m_rd[i]) % RP == 0) rp = 1;
        end
      end
      m_out[i] = {pr, rl, rp, m_level[i]};
    end
  endtask

  task automatic step(input bit s);
    btn_sync = s;
    @(posedge clk);
    model_step(s);
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [3:0] o;
      o = dut_out(i);
      chk($sformatf("model%0d_e%0d", i, m_edge), o, m_out[i]);
      chk($sformatf("excl%0d", i),
          int'(($countones(o[3:1]) > 1) || (o[1] && !o[0])), 0);
    end
  endtask

  initial begin
    int n_rep, n_press;
    checks = 0; passed = 0;
    rst_n = 1'b0; btn_sync = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset0", dut_out(0), 0);
    chk("reset1", dut_out(1), 0);
    @(negedge clk) rst_n = 1'b1;

    // Glitch rejection then a clean press.
    tbl[0]  = '{1'b1, 4'b0000}; tbl[1] = '{1'b1, 4'b0000}; tbl[2] = '{1'b1, 4'b0000};
    tbl[3]  = '{1'b0, 4'b0000}; tbl[4] = '{1'b0, 4'b0000}; tbl[5] = '{1'b1, 4'b0000};
    tbl[6]  = '{1'b1, 4'b0000}; tbl[7] = '{1'b1, 4'b0000}; tbl[8] = '{1'b1, 4'b1001};
    tbl[9]  = '{1'b1, 4'b0001}; tbl[10] = '{1'b1, 4'b0001};
    for (int v = 0; v < 11; v++) begin
      step(tbl[v].b);
      chk($sformatf("tbl%0d", v), dut_out(0), tbl[v].exp);
    end

    // Hold: repeats at press+10, +13, +16 ...
    for (int d = 3; d <= 30; d++) begin
      step(1'b1);
      chk($sformatf("rep_d%0d", d), dut_out(0), {2'b00, (d >= 10 && (d - 10) % 3 == 0), 1'b1});
    end

    // Bounce during release restarts the repeat delay.
    step(1'b0); chk("bnc_lo1", dut_out(0), 4'b0001);
    step(1'b0); chk("bnc_lo2", dut_out(0), 4'b0001);
    step(1'b1); chk("bnc_hi", dut_out(0), 4'b0001);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1);
      chk($sformatf("rerep_k%0d", k), dut_out(0), {2'b00, k == 10, 1'b1});
    end

    // Release pattern: low 2, high 1, low 4.
    step(1'b0); chk("rel_a", dut_out(0), 4'b0001);
    step(1'b0); chk("rel_b", dut_out(0), 4'b0001);
    step(1'b1); chk("rel_c", dut_out(0), 4'b0001);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0); chk($sformatf("rel_lo%0d", k), dut_out(0), 4'b0001);
    end
    step(1'b0); chk("rel_pulse", dut_out(0), 4'b0100);
    step(1'b0); chk("rel_after", dut_out(0), 4'b0000);

    // Press again; the no-repeat instance must stay silent across a 50-cycle hold.
    for (int k = 1; k <= 4; k++) begin
      step(1'b1);
      chk($sformatf("p2_0_%0d", k), dut_out(0), (k == 4) ? 4'b1001 : 4'b0000);
      chk($sformatf("p2_1_%0d", k), dut_out(1), (k == 4) ? 4'b1001 : 4'b0000);
    end
    n_rep = 0; n_press = 0;
    for (int k = 1; k <= 50; k++) begin
      step(1'b1);
      n_rep   += int'(rep_p[1]);
      n_press += int'(press_p[1]);
    end
    chk("norep_repeats", n_rep, 0);
    chk("norep_presses", n_press, 0);
    chk("norep_pressed", int'(pressed[1]), 1);

    // Asynchronous reset in HOLD_REPEAT with the button still held.
    #2 rst_n = 1'b0;
    #1;
    chk("arst0", dut_out(0), 0);
    chk("arst1", dut_out(1), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold", {dut_out(0), dut_out(1)}, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1);
      chk($sformatf("post_rst%0d", k), dut_out(0), (k == 4) ? 4'b1001 : 4'b0000);
    end

    // Random run lengths against the model.
    for (int r = 0; r < 300; r++) begin
      bit s;
      int len;
      s   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) step(s);
    end

    // Toggling every cycle never gets past debounce.
    for (int k = 0; k < 6; k++) step(1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'(k % 2 == 0));
      chk($sformatf("toggle%0d", k), {dut_out(0), dut_out(1)}, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
